fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
//
// PURPOSE
// - Decoupling FIFO between the fetch stage (2-wide bundle select + next-PC) and decode.
// - Each entry holds one fetch bundle: pc, npc, inst1, inst2, invalid2, predict_cond, bhr.
// - Fetch keeps running while decode stalls; the whole queue is discarded on mispredict or redirect.
//
// PARAMETERS
// - DEPTH    4   number of bundle entries; power of two, >= 2
// - PTR_LEN  2   log2(DEPTH); count width is PTR_LEN+1
//
// PORTS
// - clk               in   1              pipeline clock, rising edge
// - reset             in   1              asynchronous, active-high
// - enq_valid         in   1              fetch presents a bundle this cycle
// - enq_ready         out  1              queue can accept (not full)
// - enq_pc            in   `ADDR_LEN      bundle PC
// - enq_npc           in   `ADDR_LEN      next PC chosen by fetch
// - enq_inst1         in   `INSN_LEN      first instruction
// - enq_inst2         in   `INSN_LEN      second instruction
// - enq_invalid2      in   1              inst2 is not a valid slot
// - enq_predict_cond  in   1              branch-predict flag for the bundle
// - enq_bhr           in   `GSH_BHR_LEN   history snapshot for the bundle
// - flush             in   1              prmiss / redirect: discard all entries
// - deq_valid         out  1              head entry valid
// - deq_ready         in   1              decode consumes head this cycle
// - deq_pc, deq_npc, deq_inst1, deq_inst2, deq_invalid2, deq_predict_cond, deq_bhr
//                     out  same widths    head entry fields
// - count             out  PTR_LEN+1      occupied entries, 0..DEPTH
//
// BEHAVIOUR
// - Reset (async, active-high): wr_ptr=0, rd_ptr=0, count=0, all storage=0.
//   Outputs during and after reset: deq_valid=0, enq_ready=1, all deq_* fields=0, count=0.
// - Enqueue fire = enq_valid & enq_ready; dequeue fire = deq_valid & deq_ready.
// - enq_ready = (count != DEPTH). Depends only on state, never on deq_ready:
//   a full queue never accepts, even when dequeuing in the same cycle.
// - deq_valid = (count != 0). deq_* fields are read combinationally from storage[rd_ptr].
// - Latency: a bundle enqueued at edge N is visible on deq_* after edge N.
//   There is no same-cycle bypass from empty.
// - Simultaneous enqueue and dequeue fire: count unchanged, both pointers advance.
// - Pointers wrap modulo DEPTH (natural PTR_LEN-bit overflow).
//   Ordering is strict FIFO across the wrap.
// - Flush has priority over everything. At the next edge: wr_ptr=rd_ptr=0 and count=0.
//   An enqueue or dequeue presented in the flush cycle is discarded; no state change from it.
//   Storage is not cleared on flush. deq_valid=0 masks the stale data.
// - Flush while empty is a no-op apart from the pointer reset.
// - Flush and reset are independent: reset is async; flush is sampled on clk.
// - Fields are carried unmodified. The queue does not interpret invalid2 or predict_cond.
// - Assertions: count <= DEPTH; no enqueue fire when full; no dequeue fire when empty.
//
// STRUCTURE
// - constants.vh gains `FQ_ENT_LEN = 2*`ADDR_LEN + 2*`INSN_LEN + 2 + `GSH_BHR_LEN.
// - Sub-module fetch_queue_ram:
//   - DEPTH x `FQ_ENT_LEN register array.
//   - One synchronous write port, one async read port, async clear on reset.
// - Top level holds: pointers, count, handshake logic, and field pack/unpack.
//
// TESTING
// 1. Reset mid-run with 3 entries held:
//    -> immediately deq_valid=0, count=0, enq_ready=1, deq_inst1=0.
// 2. Enqueue pc=0x100,0x108,0x110,0x118 back-to-back with deq_ready=0:
//    -> count=4, enq_ready=0.
//    A 5th enq (pc=0x120) is held off.
//    Then deq_ready=1 drains the queue in order: 0x100 first.
// 3. Full queue with enq_valid=1 and deq_ready=1 in the same cycle:
//    -> dequeue only, count 4->3.
//    pc=0x120 is accepted on the following cycle.
// 4. Steady streaming of 10 bundles with enq_valid=deq_ready=1 from empty:
//    -> first deq_valid one cycle after the first enqueue, count stays 1.
//    All 10 arrive in order across the pointer wrap.
// 5. Flush with 2 entries held plus a concurrent enq of pc=0x200:
//    -> next cycle count=0, deq_valid=0.
//    A subsequent enq of pc=0x300 appears at the head, not 0x200.
// 6. Enq with invalid2=1, predict_cond=1, bhr=all-ones, inst2=0xDEADBEEF:
//    -> fields are dequeued bit-exact.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared widths and the bundle layout for the fetch-to-decode queue.
// One fq_entry_t is one fetch bundle as stored in a single queue slot.
package fetch_queue_pkg;
   localparam int ADDR_LEN    = 32;
   localparam int INSN_LEN    = 32;
   localparam int GSH_BHR_LEN = 10;
   localparam int FQ_ENT_LEN  = 2*ADDR_LEN + 2*INSN_LEN + 2 + GSH_BHR_LEN;

   typedef struct packed {
      logic [ADDR_LEN-1:0]    pc;
      logic [ADDR_LEN-1:0]    npc;
      logic [INSN_LEN-1:0]    inst1;
      logic [INSN_LEN-1:0]    inst2;
      logic                   invalid2;
      logic                   predict_cond;
      logic [GSH_BHR_LEN-1:0] bhr;
   } fq_entry_t;
endpackage

// File: rtl/fetch_queue_ram.sv
// Bundle storage: DEPTH x WIDTH register array.
// It has one synchronous write port, one asynchronous read port and an async clear.
module fetch_queue_ram
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int PTR_LEN = 2,
   parameter int WIDTH   = FQ_ENT_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic [PTR_LEN-1:0] waddr,
   input  logic [WIDTH-1:0]   wdata,
   input  logic [PTR_LEN-1:0] raddr,
   output logic [WIDTH-1:0]   rdata
);
   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) mem_q <= '0;
      else       mem_q <= mem_d;
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between fetch and decode, holding one bundle per entry.
// A flush discards every entry; the storage is left as is and deq_valid masks it.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int PTR_LEN = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq_valid,
   output logic                   enq_ready,
   input  logic [ADDR_LEN-1:0]    enq_pc,
   input  logic [ADDR_LEN-1:0]    enq_npc,
   input  logic [INSN_LEN-1:0]    enq_inst1,
   input  logic [INSN_LEN-1:0]    enq_inst2,
   input  logic                   enq_invalid2,
   input  logic                   enq_predict_cond,
   input  logic [GSH_BHR_LEN-1:0] enq_bhr,
   input  logic                   flush,
   output logic                   deq_valid,
   input  logic                   deq_ready,
   output logic [ADDR_LEN-1:0]    deq_pc,
   output logic [ADDR_LEN-1:0]    deq_npc,
   output logic [INSN_LEN-1:0]    deq_inst1,
   output logic [INSN_LEN-1:0]    deq_inst2,
   output logic                   deq_invalid2,
   output logic                   deq_predict_cond,
   output logic [GSH_BHR_LEN-1:0] deq_bhr,
   output logic [PTR_LEN:0]       count
);
   localparam logic [PTR_LEN:0]   FULL_CNT = (PTR_LEN+1)'(DEPTH);
   localparam logic [PTR_LEN:0]   CNT_ONE  = (PTR_LEN+1)'(1);
   localparam logic [PTR_LEN-1:0] PTR_ONE  = PTR_LEN'(1);

   logic [PTR_LEN-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_LEN:0]   count_q, count_d;
   logic               enq_fire, deq_fire;
   fq_entry_t          wr_entry, rd_entry;

   // enq_ready looks only at occupancy, so a full queue refuses even while draining.
   assign enq_ready = (count_q != FULL_CNT);
   assign deq_valid = (count_q != '0);
   assign enq_fire  = enq_valid & enq_ready;
   assign deq_fire  = deq_valid & deq_ready;
   assign count     = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (deq_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (enq_fire && !deq_fire)      count_d = count_q + CNT_ONE;
         else if (!enq_fire && deq_fire) count_d = count_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign wr_entry = '{enq_pc, enq_npc, enq_inst1, enq_inst2,
                       enq_invalid2, enq_predict_cond, enq_bhr};

   fetch_queue_ram #(.DEPTH(DEPTH), .PTR_LEN(PTR_LEN), .WIDTH(FQ_ENT_LEN)) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (enq_fire & ~flush),
      .waddr (wr_ptr_q),
      .wdata (wr_entry),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

   assign deq_pc           = rd_entry.pc;
   assign deq_npc          = rd_entry.npc;
   assign deq_inst1        = rd_entry.inst1;
   assign deq_inst2        = rd_entry.inst2;
   assign deq_invalid2     = rd_entry.invalid2;
   assign deq_predict_cond = rd_entry.predict_cond;
   assign deq_bhr          = rd_entry.bhr;

`ifndef SYNTHESIS
   a_count_bound: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);
   a_no_enq_full: assert property (@(posedge clk) disable iff (reset)
                                   !(enq_fire && count_q == FULL_CNT));
   a_no_deq_empty: assert property (@(posedge clk) disable iff (reset)
                                    !(deq_fire && count_q == '0));
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, all checked
// against a queue-based model of the FIFO.
module tb_fetch_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        enq_valid, enq_ready;
   logic [31:0] enq_pc, enq_npc, enq_inst1, enq_inst2;
   logic        enq_invalid2, enq_predict_cond;
   logic [9:0]  enq_bhr;
   logic        flush;
   logic        deq_valid, deq_ready;
   logic [31:0] deq_pc, deq_npc, deq_inst1, deq_inst2;
   logic        deq_invalid2, deq_predict_cond;
   logic [9:0]  deq_bhr;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] pc, npc, inst1, inst2;
      logic        inv2, pred;
      logic [9:0]  bhr;
   } bundle_t;
   bundle_t model_q[$];

   fetch_queue #(.DEPTH(DEPTH), .PTR_LEN(2)) dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_pc(enq_pc), .enq_npc(enq_npc), .enq_inst1(enq_inst1), .enq_inst2(enq_inst2),
      .enq_invalid2(enq_invalid2), .enq_predict_cond(enq_predict_cond), .enq_bhr(enq_bhr),
      .flush(flush),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_pc(deq_pc), .deq_npc(deq_npc), .deq_inst1(deq_inst1), .deq_inst2(deq_inst2),
      .deq_invalid2(deq_invalid2), .deq_predict_cond(deq_predict_cond), .deq_bhr(deq_bhr),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of bundles updated from the pre-edge inputs.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         model_q.delete();
      end else if (flush) begin
         model_q.delete();
      end else begin
         bundle_t b;
         bit do_deq, do_enq;
         do_deq = (model_q.size() != 0) && deq_ready;
         do_enq = enq_valid && (model_q.size() != DEPTH);
         b.pc = enq_pc; b.npc = enq_npc; b.inst1 = enq_inst1; b.inst2 = enq_inst2;
         b.inv2 = enq_invalid2; b.pred = enq_predict_cond; b.bhr = enq_bhr;
         if (do_deq) void'(model_q.pop_front());
         if (do_enq) model_q.push_back(b);
      end
   end

   always @(negedge clk) begin
      check("deq_valid", 64'(deq_valid), 64'(model_q.size() != 0));
      check("enq_ready", 64'(enq_ready), 64'(model_q.size() != DEPTH));
      check("count", 64'(count), 64'(model_q.size()));
      if (model_q.size() != 0) begin
         check("head_pc",    64'(deq_pc),    64'(model_q[0].pc));
         check("head_npc",   64'(deq_npc),   64'(model_q[0].npc));
         check("head_inst1", 64'(deq_inst1), 64'(model_q[0].inst1));
         check("head_inst2", 64'(deq_inst2), 64'(model_q[0].inst2));
         check("head_inv2",  64'(deq_invalid2),     64'(model_q[0].inv2));
         check("head_pred",  64'(deq_predict_cond), 64'(model_q[0].pred));
         check("head_bhr",   64'(deq_bhr),   64'(model_q[0].bhr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_enq(input logic [31:0] pc);
      enq_valid        = 1'b1;
      enq_pc           = pc;
      enq_npc          = pc + 32'd8;
      enq_inst1        = ~pc;
      enq_inst2        = pc ^ 32'h5A5A_0000;
      enq_invalid2     = pc[3];
      enq_predict_cond = pc[4];
      enq_bhr          = pc[9:0];
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; deq_ready = 1'b0;
      set_enq(32'h0); enq_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_deq_valid", 64'(deq_valid), 64'd0);
      check("rst_enq_ready", 64'(enq_ready), 64'd1);
      check("rst_count", 64'(count), 64'd0);
      check("rst_deq_inst1", 64'(deq_inst1), 64'd0);
      reset = 1'b0;

      // 1: async reset while holding three entries
      for (int i = 0; i < 3; i++) begin set_enq(32'h40 + 32'(i*8)); tick(); end
      enq_valid = 1'b0;
      check("t1_count3", 64'(count), 64'd3);
      #2 reset = 1'b1;
      #1;
      check("t1_deq_valid", 64'(deq_valid), 64'd0);
      check("t1_count", 64'(count), 64'd0);
      check("t1_enq_ready", 64'(enq_ready), 64'd1);
      check("t1_deq_inst1", 64'(deq_inst1), 64'd0);
      @(negedge clk); #1 reset = 1'b0;
      tick();

      // 2: fill, hold off a fifth enqueue
      for (int i = 0; i < 4; i++) begin set_enq(32'h100 + 32'(i*8)); tick(); end
      check("t2_count", 64'(count), 64'd4);
      check("t2_enq_ready", 64'(enq_ready), 64'd0);
      set_enq(32'h120); tick();
      check("t2_still_full", 64'(count), 64'd4);
      check("t2_head", 64'(deq_pc), 64'h100);

      // 3: full with enq and deq together -> dequeue only
      deq_ready = 1'b1; tick();
      check("t3_count", 64'(count), 64'd3);
      check("t3_head", 64'(deq_pc), 64'h108);
      deq_ready = 1'b0; tick();
      check("t3_accept", 64'(count), 64'd4);
      enq_valid = 1'b0; deq_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t3_drain", 64'(deq_pc), 64'(32'h108 + 32'(i*8)));
         tick();
      end
      check("t3_empty", 64'(deq_valid), 64'd0);

      // 4: streaming ten bundles from empty
      for (int i = 0; i < 10; i++) begin
         set_enq(32'h400 + 32'(i*8)); tick();
         check("t4_valid", 64'(deq_valid), 64'd1);
         check("t4_count", 64'(count), 64'd1);
         check("t4_pc", 64'(deq_pc), 64'(32'h400 + 32'(i*8)));
      end
      enq_valid = 1'b0; tick();
      check("t4_empty", 64'(count), 64'd0);

      // 5: flush with a concurrent enqueue
      deq_ready = 1'b0;
      set_enq(32'h500); tick();
      set_enq(32'h508); tick();
      set_enq(32'h200); flush = 1'b1; tick();
      flush = 1'b0; enq_valid = 1'b0;
      check("t5_count", 64'(count), 64'd0);
      check("t5_valid", 64'(deq_valid), 64'd0);
      set_enq(32'h300); tick();
      enq_valid = 1'b0;
      check("t5_head", 64'(deq_pc), 64'h300);
      check("t5_count1", 64'(count), 64'd1);
      deq_ready = 1'b1; tick();

      // 6: fields are carried bit-exact
      deq_ready = 1'b0;
      set_enq(32'h600);
      enq_invalid2 = 1'b1; enq_predict_cond = 1'b1; enq_bhr = '1; enq_inst2 = 32'hDEADBEEF;
      tick();
      enq_valid = 1'b0;
      check("t6_inst2", 64'(deq_inst2), 64'hDEADBEEF);
      check("t6_inv2", 64'(deq_invalid2), 64'd1);
      check("t6_pred", 64'(deq_predict_cond), 64'd1);
      check("t6_bhr", 64'(deq_bhr), 64'h3FF);
      check("t6_npc", 64'(deq_npc), 64'h608);
      deq_ready = 1'b1; tick();

      // random traffic with varying fill pressure
      for (int ph = 0; ph < 4; ph++) begin
         for (int c = 0; c < 500; c++) begin
            enq_valid        = ($urandom_range(0, 3) < 32'(ph + 1));
            deq_ready        = ($urandom_range(0, 3) >= 32'(ph));
            flush            = ($urandom_range(0, 49) == 0);
            enq_pc           = $urandom;
            enq_npc          = $urandom;
            enq_inst1        = $urandom;
            enq_inst2        = $urandom;
            enq_invalid2     = 1'($urandom);
            enq_predict_cond = 1'($urandom);
            enq_bhr          = 10'($urandom);
            tick();
         end
      end
      enq_valid = 1'b0; flush = 1'b0; deq_ready = 1'b1;
      repeat (6) tick();
      check("final_empty", 64'(count), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
